// File: rtl/route_unit_xy.sv
// route_unit_xy: single-input XY dimension-order routing unit for the mesh router.
// Pops one packet at a time from its input FIFO and routes X first, then Y, against the
// run-time local coordinates. It then writes the packet to the one selected output FIFO,
// waiting as long as that FIFO is full. A route that points back at the input this
// instance serves (a U-turn, or a PE->PE loopback) is dropped instead of forwarded.
// Saturating counters record the number of packets sent and the number dropped.
module route_unit_xy #(
  parameter int PKT_W     = 64,
  parameter int COORD_W   = 4,
  parameter int NUM_PORTS = 5,
  parameter int IN_DIR    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COORD_W-1:0]   local_x,
  input  logic [COORD_W-1:0]   local_y,
  input  logic                 empty,
  input  logic [PKT_W-1:0]     in_packet,
  output logic                 read_en,
  input  logic [NUM_PORTS-1:0] full_vec,
  output logic [NUM_PORTS-1:0] req_vec,
  output logic [PKT_W-1:0]     pkt_out,
  output logic [2:0]           dst_port,
  output logic                 busy,
  output logic                 drop_pulse,
  output logic [CNT_W-1:0]     sent_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  // Output port encoding shared by the whole mesh
  localparam logic [2:0] PORT_E  = 3'd0;
  localparam logic [2:0] PORT_W  = 3'd1;
  localparam logic [2:0] PORT_S  = 3'd2;
  localparam logic [2:0] PORT_N  = 3'd3;
  localparam logic [2:0] PORT_PE = 3'd4;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DROP} state_t;

  state_t             state_reg;
  logic [PKT_W-1:0]   pkt_reg;
  logic [2:0]         dst_port_reg;
  logic [CNT_W-1:0]   sent_cnt_reg;
  logic [CNT_W-1:0]   drop_cnt_reg;

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic [2:0]         route_port;
  logic               illegal;
  logic               send_fire;

  // Destination header sits in the top bits of the packet: X field, then Y field
  assign dx = in_packet[PKT_W-1 -: COORD_W];
  assign dy = in_packet[PKT_W-1-COORD_W -: COORD_W];

  // X-first dimension-order route of the word on the FIFO read port
  always_comb begin
    if (dx > local_x)      route_port = PORT_E;
    else if (dx < local_x) route_port = PORT_W;
    else if (dy > local_y) route_port = PORT_N;
    else if (dy < local_y) route_port = PORT_S;
    else                   route_port = PORT_PE;
  end

  // Sending back out of the port we arrived on is never legal
  assign illegal = (route_port == 3'(IN_DIR));

  // One write strobe per output; only the latched target's own full flag gates it
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
    assign req_vec[gi] = (state_reg == SEND) && (dst_port_reg == 3'(gi)) && !full_vec[gi];
  end

  assign send_fire = |req_vec;

  // Pop strobe: from IDLE, or on the sending cycle so packets stream back to back
  always_comb begin
    read_en = 1'b0;
    case (state_reg)
      IDLE:    read_en = reset && !empty;
      SEND:    read_en = send_fire && !empty;
      default: read_en = 1'b0;
    endcase
  end

  assign busy       = (state_reg != IDLE);
  assign drop_pulse = (state_reg == DROP);
  assign pkt_out    = pkt_reg;
  assign dst_port   = dst_port_reg;
  assign sent_cnt   = sent_cnt_reg;
  assign drop_cnt   = drop_cnt_reg;

  // Control FSM with packet/port latches and saturating statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      pkt_reg      <= '0;
      dst_port_reg <= '0;
      sent_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (read_en) state_reg <= FETCH;
        end
        FETCH: begin
          // FIFO data is valid the cycle after the pop
          pkt_reg      <= in_packet;
          dst_port_reg <= route_port;
          state_reg    <= illegal ? DROP : SEND;
        end
        SEND: begin
          // Held indefinitely while the target is full; nothing else can pre-empt it
          if (send_fire) begin
            if (sent_cnt_reg != '1) sent_cnt_reg <= sent_cnt_reg + CNT_W'(1);
            state_reg <= read_en ? FETCH : IDLE;
          end
        end
        DROP: begin
          if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
